sha_access_arbiter: RTL and testbench
=====================================

SHA_ACCESS_ARBITER -- requirements
Module: sha_access_arbiter

Interface
REQ-001 Parameter N_REQ, default 3: number of requesters sharing the SHA-256 core (2..8).
REQ-002 Parameter HOLD_TIMEOUT, default 255: maximum idle cycles a multi-block owner may keep the grant.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 req_valid  in  N_REQ  requester i presents a 512-bit block.
REQ-006 req_block  in  N_REQ*512  block data, requester i in slice [i*512 +: 512].
REQ-007 req_first  in  N_REQ  block is the first of a message (maps to sha_init).
REQ-008 req_last  in  N_REQ  block is the last of a message.
REQ-009 req_accept  out  N_REQ  one-cycle pulse: block of requester i issued to the core.
REQ-010 rsp_valid  out  N_REQ  one-cycle pulse: final digest for requester i on rsp_digest.
REQ-011 rsp_digest  out  256  registered digest, held until the next rsp_valid.
REQ-012 arb_err  out  N_REQ  one-cycle pulse: grant revoked from requester i by hold timeout.
REQ-013 sha_block  out  512  block to the core; sha_init / sha_next  out  1 each  one-cycle start pulses.
REQ-014 sha_ready, sha_digest_valid  in  1 each; sha_digest  in  256  core status and result.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT_LOW, WAIT_DONE, HOLD.
REQ-016 IDLE: when sha_ready=1 and any req_valid&req_first is set, grant the round-robin winner, starting the search at last_grant+1 mod N_REQ; go to ISSUE.
REQ-017 In IDLE, req_valid without req_first SHALL be ignored and not accepted.
REQ-018 ISSUE (1 cycle): drive sha_block from the owner's slice; pulse sha_init if req_first, else sha_next; pulse req_accept[owner]; latch req_last; go to WAIT_LOW.
REQ-019 WAIT_LOW: wait for sha_ready=0, then go to WAIT_DONE; if sha_ready stays 1 for 4 cycles, also go to WAIT_DONE.
REQ-020 WAIT_DONE: on sha_ready=1, if the latched last=1 and sha_digest_valid=1, capture sha_digest into rsp_digest, pulse rsp_valid[owner], set last_grant=owner, go to IDLE; otherwise go to HOLD.
REQ-021 HOLD: the grant stays with the owner; owner req_valid (first or not) goes to ISSUE next cycle; other requesters are not accepted.
REQ-022 HOLD: a counter SHALL reset on entry and increment each cycle without owner req_valid; at HOLD_TIMEOUT, pulse arb_err[owner], set last_grant=owner, go to IDLE.
REQ-023 Owner req_first=1 in HOLD restarts the message with sha_init; this is not an error.
REQ-024 sha_block SHALL be zero outside ISSUE; sha_init and sha_next are never both high.
REQ-025 At most one bit each of req_accept, rsp_valid and arb_err SHALL be high in any cycle.
REQ-026 Accept-to-core latency SHALL be 0 cycles (same ISSUE cycle); digest-to-rsp_valid SHALL be 1 cycle.
REQ-027 A requester dropping req_valid before acceptance SHALL lose its turn without side effects.

Reset
REQ-028 With rst_n=0 at a clock edge, state=IDLE, last_grant=N_REQ-1, hold counter=0, and all outputs 0 (rsp_digest=0).
REQ-029 Reset mid-message SHALL abandon the message without emitting rsp_valid or arb_err; the core is not re-initialised until the next req_first.

Structure
REQ-030 Package sha_arb_pkg SHALL hold the state enum, SHA_BLOCK_W=512, SHA_DIGEST_W=256, and the WAIT_LOW guard length of 4.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (request vector plus last-grant pointer in; one-hot grant out; combinational).
REQ-032 Owner index width SHALL be $clog2(N_REQ); the hold counter width SHALL be $clog2(HOLD_TIMEOUT+1).

Verification
REQ-033 Single block: req 0 presents first=last=1 with block 'abc'-padded; the core model returns digest ba7816bf... -> req_accept[0] in ISSUE, rsp_valid[0] one cycle after digest_valid, rsp_digest=ba7816bf....
REQ-034 Contention: reqs 0, 1 and 2 all present first=last=1 in the same cycle after reset -> grant order 0,1,2; the next simultaneous round starts at 0.
REQ-035 Multi-block: req 1 sends a 3-block message while req 2 waits -> req 2 is not accepted until after rsp_valid[1]; sha_init once, then sha_next twice.
REQ-036 Timeout: req 0 sends a non-last block and then idles -> arb_err[0] after exactly 255 HOLD cycles; req 1 granted next.
REQ-037 Reset mid-WAIT_DONE: rst_n=0 for 1 cycle -> all outputs 0 next cycle; no rsp_valid when the stale digest_valid arrives.
REQ-038 Non-first in IDLE: req 2 presents first=0 -> no req_accept, no sha_init or sha_next, FSM remains IDLE.

Source files
------------

// File: rtl/sha_arb_pkg.sv
// Shared definitions for the SHA-256 access arbiter.
//   - arb_state_e    : arbiter FSM states
//   - SHA_BLOCK_W    : message block width presented to the core
//   - SHA_DIGEST_W   : digest width returned by the core
//   - WAIT_LOW_GUARD : cycles to wait for the core to drop sha_ready after a start pulse
package sha_arb_pkg;

  localparam int SHA_BLOCK_W    = 512;
  localparam int SHA_DIGEST_W   = 256;
  localparam int WAIT_LOW_GUARD = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LOW,
    WAIT_DONE,
    HOLD
  } arb_state_e;

endpackage

// File: rtl/sha_access_arbiter_rr_arbiter.sv
// Combinational round-robin selector.
//   req        : request vector, one bit per requester
//   last_grant : index of the most recent owner; search starts one past it
//   gnt        : one-hot grant (all zero when no request is set)
module rr_arbiter #(
  parameter  int N_REQ = 3,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] gnt
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    // Walk the ring starting just after last_grant; the first set request wins.
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IDX_W'((int'(last_grant) + k) % N_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sha_access_arbiter.sv
// Shares one SHA-256 core among N_REQ requesters.
// A requester wins the core with a first block (round-robin among first blocks),
// then keeps it until its last block's digest is returned or it stays idle for
// HOLD_TIMEOUT cycles between blocks.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   req_valid/req_first/req_last    per-requester block handshake and framing
//   req_block                       per-requester 512-bit block, slice i*512 +: 512
//   req_accept                      pulse: requester's block handed to the core
//   rsp_valid / rsp_digest          pulse + registered final digest
//   arb_err                         pulse: owner's grant revoked by hold timeout
//   sha_block, sha_init, sha_next   core block and start pulses
//   sha_ready, sha_digest_valid,
//   sha_digest                      core status and result
module sha_access_arbiter
  import sha_arb_pkg::*;
#(
  parameter int N_REQ        = 3,
  parameter int HOLD_TIMEOUT = 255
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_REQ-1:0]               req_valid,
  input  logic [N_REQ*SHA_BLOCK_W-1:0]   req_block,
  input  logic [N_REQ-1:0]               req_first,
  input  logic [N_REQ-1:0]               req_last,
  output logic [N_REQ-1:0]               req_accept,
  output logic [N_REQ-1:0]               rsp_valid,
  output logic [SHA_DIGEST_W-1:0]        rsp_digest,
  output logic [N_REQ-1:0]               arb_err,
  output logic [SHA_BLOCK_W-1:0]         sha_block,
  output logic                           sha_init,
  output logic                           sha_next,
  input  logic                           sha_ready,
  input  logic                           sha_digest_valid,
  input  logic [SHA_DIGEST_W-1:0]        sha_digest
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(HOLD_TIMEOUT + 1);
  localparam int GRD_W = $clog2(WAIT_LOW_GUARD);

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [IDX_W-1:0]        last_grant_q, last_grant_d;
  logic                    last_q, last_d;
  logic                    in_msg_q, in_msg_d;
  logic [CNT_W-1:0]        hold_cnt_q, hold_cnt_d;
  logic [GRD_W-1:0]        guard_q, guard_d;
  logic [N_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [N_REQ-1:0]        arb_err_q, arb_err_d;
  logic [SHA_DIGEST_W-1:0] rsp_digest_q, rsp_digest_d;

  logic [N_REQ-1:0]        rr_req;
  logic [N_REQ-1:0]        rr_gnt;
  logic [IDX_W-1:0]        gnt_idx;
  logic                    owner_valid;
  logic                    owner_first;
  logic                    owner_last;
  logic [SHA_BLOCK_W-1:0]  owner_block;

  // Only message starts compete for the core; continuation blocks are
  // accepted solely from the current owner while it holds the grant.
  assign rr_req = req_valid & req_first;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req        (rr_req),
    .last_grant (last_grant_q),
    .gnt        (rr_gnt)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (rr_gnt[i]) gnt_idx = IDX_W'(i);
    end
  end

  assign owner_valid = req_valid[owner_q];
  assign owner_first = req_first[owner_q];
  assign owner_last  = req_last[owner_q];
  assign owner_block = req_block[int'(owner_q)*SHA_BLOCK_W +: SHA_BLOCK_W];

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    last_d       = last_q;
    in_msg_d     = in_msg_q;
    hold_cnt_d   = hold_cnt_q;
    guard_d      = guard_q;
    rsp_valid_d  = '0;
    arb_err_d    = '0;
    rsp_digest_d = rsp_digest_q;
    req_accept   = '0;
    sha_block    = '0;
    sha_init     = 1'b0;
    sha_next     = 1'b0;

    case (state_q)
      IDLE: begin
        in_msg_d = 1'b0;
        if (sha_ready && (|rr_req)) begin
          owner_d = gnt_idx;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        // Outside a message only a first block may start the core; a
        // requester that withdrew loses its turn without touching the core.
        if (owner_valid && (in_msg_q || owner_first)) begin
          req_accept[owner_q] = 1'b1;
          sha_block           = owner_block;
          sha_init            = owner_first;
          sha_next            = !owner_first;
          last_d              = owner_last;
          guard_d             = '0;
          state_d             = WAIT_LOW;
        end else if (in_msg_q) begin
          hold_cnt_d = '0;
          state_d    = HOLD;
        end else begin
          state_d = IDLE;
        end
      end

      WAIT_LOW: begin
        // A core that never drops ready is tolerated after the guard expires.
        if (!sha_ready || (guard_q == GRD_W'(WAIT_LOW_GUARD - 1))) begin
          state_d = WAIT_DONE;
        end else begin
          guard_d = guard_q + GRD_W'(1);
        end
      end

      WAIT_DONE: begin
        if (sha_ready) begin
          if (last_q && sha_digest_valid) begin
            rsp_digest_d         = sha_digest;
            rsp_valid_d[owner_q] = 1'b1;
            last_grant_d         = owner_q;
            state_d              = IDLE;
          end else begin
            in_msg_d   = 1'b1;
            hold_cnt_d = '0;
            state_d    = HOLD;
          end
        end
      end

      HOLD: begin
        if (owner_valid) begin
          state_d = ISSUE;
        end else if (hold_cnt_q == CNT_W'(HOLD_TIMEOUT - 1)) begin
          arb_err_d[owner_q] = 1'b1;
          last_grant_d       = owner_q;
          state_d            = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_grant_q <= IDX_W'(N_REQ - 1);
      last_q       <= 1'b0;
      in_msg_q     <= 1'b0;
      hold_cnt_q   <= '0;
      guard_q      <= '0;
      rsp_valid_q  <= '0;
      arb_err_q    <= '0;
      rsp_digest_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      last_q       <= last_d;
      in_msg_q     <= in_msg_d;
      hold_cnt_q   <= hold_cnt_d;
      guard_q      <= guard_d;
      rsp_valid_q  <= rsp_valid_d;
      arb_err_q    <= arb_err_d;
      rsp_digest_q <= rsp_digest_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign arb_err    = arb_err_q;
  assign rsp_digest = rsp_digest_q;

endmodule

// File: tb/tb_sha_access_arbiter.sv
module tb_sha_access_arbiter;

  localparam int N  = 3;
  localparam int BW = 512;
  localparam int DW = 256;

  localparam logic [BW-1:0] ABC_BLK = {32'h61626380, 416'h0, 64'h18};
  localparam logic [DW-1:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*BW-1:0] req_block = '0;
  logic [N-1:0]    req_first = '0;
  logic [N-1:0]    req_last = '0;
  logic [N-1:0]    req_accept, rsp_valid, arb_err;
  logic [DW-1:0]   rsp_digest;
  logic [BW-1:0]   sha_block;
  logic            sha_init, sha_next;
  logic            sha_ready = 1'b1;
  logic            sha_digest_valid = 1'b0;
  logic [DW-1:0]   sha_digest = '0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sha_access_arbiter #(.N_REQ(N), .HOLD_TIMEOUT(255)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_block        (req_block),
    .req_first        (req_first),
    .req_last         (req_last),
    .req_accept       (req_accept),
    .rsp_valid        (rsp_valid),
    .rsp_digest       (rsp_digest),
    .arb_err          (arb_err),
    .sha_block        (sha_block),
    .sha_init         (sha_init),
    .sha_next         (sha_next),
    .sha_ready        (sha_ready),
    .sha_digest_valid (sha_digest_valid),
    .sha_digest       (sha_digest)
  );

  // Core model: the 'abc' block hashes to the known SHA-256 digest, any other
  // block to an arbitrary but deterministic mix of its halves.
  function automatic logic [DW-1:0] core_fn(input logic [BW-1:0] b);
    if (b == ABC_BLK) return ABC_DIG;
    return b[511:256] ^ {b[127:0], b[255:128]};
  endfunction

  function automatic logic [N-1:0] onehot(input int o);
    logic [N-1:0] v;
    v = '0;
    if (o >= 0 && o < N) v[o] = 1'b1;
    return v;
  endfunction

  int fixed_lat = 0;
  int busy = 0;

  always @(posedge clk) begin
    sha_digest_valid <= 1'b0;
    if (busy > 0) begin
      busy <= busy - 1;
      if (busy == 1) begin
        sha_ready        <= 1'b1;
        sha_digest_valid <= 1'b1;
      end
    end else if (sha_init || sha_next) begin
      sha_ready  <= 1'b0;
      busy       <= (fixed_lat > 0) ? fixed_lat : int'($urandom_range(4, 1));
      sha_digest <= core_fn(sha_block);
    end
  end

  // Requester traffic: nblk[i] blocks in blks[i], cur[i] is the next to send.
  int            nblk [N];
  int            cur  [N];
  logic [BW-1:0] blks [N][4];
  int            model_last;
  int            grant_log[$];
  int            init_cnt, next_cnt;

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (cur[i] < nblk[i]) begin
        req_valid[i]          = 1'b1;
        req_first[i]          = (cur[i] == 0);
        req_last[i]           = (cur[i] == nblk[i] - 1);
        req_block[i*BW +: BW] = blks[i][cur[i]];
      end else begin
        req_valid[i]          = 1'b0;
        req_first[i]          = 1'b0;
        req_last[i]           = 1'b0;
        req_block[i*BW +: BW] = '0;
      end
    end
  endtask

  task automatic clear_traffic();
    for (int i = 0; i < N; i++) begin
      nblk[i] = 0;
      cur[i]  = 0;
    end
    drive_inputs();
  endtask

  function automatic logic [BW-1:0] rand_blk();
    logic [BW-1:0] b;
    for (int w = 0; w < BW / 32; w++) b[w*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic do_reset();
    clear_traffic();
    rst_n = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_last = N - 1;
  endtask

  // Reference: every loaded requester presents its first block from the start,
  // so messages run in ring order from the requester after the last owner, and
  // each finishes with the digest of its final block before the next starts.
  task automatic run_traffic(input int budget);
    int           exp_order[$];
    int           done, total, o, a;
    logic [N-1:0] acc;
    logic         prev_dv;
    exp_order = {};
    for (int k = 1; k <= N; k++) begin
      if (nblk[(model_last + k) % N] > 0) exp_order.push_back((model_last + k) % N);
    end
    total = exp_order.size();
    grant_log = {};
    init_cnt = 0;
    next_cnt = 0;
    done = 0;
    prev_dv = 1'b0;
    drive_inputs();
    for (int cyc = 0; cyc < budget && done < total; cyc++) begin
      @(negedge clk);
      acc = req_accept;
      a = -1;
      o = (exp_order.size() > 0) ? exp_order[0] : -1;
      for (int i = 0; i < N; i++) if (acc[i]) a = i;
      if (acc != '0) begin
        grant_log.push_back(a);
        tests_run++;
        if (acc !== onehot(o)) begin
          tests_failed++;
          $display("FAIL accept_owner: got %b expected %b", acc, onehot(o));
        end
        if (o >= 0 && cur[o] < nblk[o]) begin
          tests_run++;
          if (sha_block !== blks[o][cur[o]]) begin
            tests_failed++;
            $display("FAIL sha_block: req %0d block %0d data differs", o, cur[o]);
          end
          tests_run++;
          if ({sha_init, sha_next} !== ((cur[o] == 0) ? 2'b10 : 2'b01)) begin
            tests_failed++;
            $display("FAIL start_pulse: init/next=%b%b for block %0d", sha_init, sha_next, cur[o]);
          end
        end
        init_cnt += int'(sha_init);
        next_cnt += int'(sha_next);
      end else begin
        tests_run++;
        if (sha_block !== '0 || sha_init !== 1'b0 || sha_next !== 1'b0) begin
          tests_failed++;
          $display("FAIL core_quiet: init=%b next=%b block_nonzero=%b without accept",
                   sha_init, sha_next, (sha_block != '0));
        end
      end
      if (rsp_valid !== '0) begin
        tests_run++;
        if (rsp_valid !== onehot(o)) begin
          tests_failed++;
          $display("FAIL rsp_owner: got %b expected %b", rsp_valid, onehot(o));
        end
        if (o >= 0) begin
          tests_run++;
          if (rsp_digest !== core_fn(blks[o][nblk[o]-1])) begin
            tests_failed++;
            $display("FAIL rsp_digest: got %h expected %h", rsp_digest, core_fn(blks[o][nblk[o]-1]));
          end
          model_last = o;
          void'(exp_order.pop_front());
        end
        tests_run++;
        if (prev_dv !== 1'b1) begin
          tests_failed++;
          $display("FAIL rsp_latency: digest_valid previous cycle=%b expected 1", prev_dv);
        end
        done++;
      end
      if (arb_err !== '0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_arb_err: got %b expected 0", arb_err);
      end
      prev_dv = sha_digest_valid;
      @(posedge clk);
      #1;
      if (a >= 0) cur[a]++;
      drive_inputs();
    end
    tests_run++;
    if (done != total) begin
      tests_failed++;
      $display("FAIL traffic_timeout: %0d of %0d messages completed", done, total);
    end
    clear_traffic();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = N'($urandom);
    req_first = N'($urandom);
    req_last  = N'($urandom);
    req_block = {rand_blk(), rand_blk(), rand_blk()};
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (req_accept !== '0) begin tests_failed++; $display("FAIL reset_accept: got %b expected 0", req_accept); end
    tests_run++;
    if (rsp_valid !== '0) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    tests_run++;
    if (arb_err !== '0) begin tests_failed++; $display("FAIL reset_arb_err: got %b expected 0", arb_err); end
    tests_run++;
    if (rsp_digest !== '0) begin tests_failed++; $display("FAIL reset_rsp_digest: got %h expected 0", rsp_digest); end
    tests_run++;
    if (sha_block !== '0) begin tests_failed++; $display("FAIL reset_sha_block: nonzero, expected 0"); end
    tests_run++;
    if ({sha_init, sha_next} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_start: init/next=%b%b expected 00", sha_init, sha_next);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    fixed_lat = 3;
    nblk[0] = 1;
    blks[0][0] = ABC_BLK;
    run_traffic(100);
    tests_run++;
    if (grant_log.size() != 1 || grant_log[0] != 0) begin
      tests_failed++;
      $display("FAIL single_grant: %0d grants, expected one to req 0", grant_log.size());
    end
    @(negedge clk);
    tests_run++;
    if (rsp_valid !== '0) begin tests_failed++; $display("FAIL single_rsp_pulse: got %b expected 0", rsp_valid); end
    tests_run++;
    if (rsp_digest !== ABC_DIG) begin
      tests_failed++;
      $display("FAIL single_digest_hold: got %h expected %h", rsp_digest, ABC_DIG);
    end
  endtask

  task automatic test_contention();
    do_reset();
    fixed_lat = 0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) begin
        nblk[i] = 1;
        blks[i][0] = rand_blk();
      end
      run_traffic(200);
      tests_run++;
      if (grant_log.size() != 3 || grant_log[0] != 0 || grant_log[1] != 1 || grant_log[2] != 2) begin
        tests_failed++;
        $display("FAIL contention_order round %0d: got %p expected 0,1,2", r, grant_log);
      end
    end
  endtask

  task automatic test_multi_block();
    for (int b = 0; b < 3; b++) blks[1][b] = rand_blk();
    blks[2][0] = rand_blk();
    nblk[1] = 3;
    nblk[2] = 1;
    run_traffic(300);
    tests_run++;
    if (grant_log.size() != 4 || grant_log[0] != 1 || grant_log[1] != 1 ||
        grant_log[2] != 1 || grant_log[3] != 2) begin
      tests_failed++;
      $display("FAIL multi_order: got %p expected 1,1,1,2", grant_log);
    end
    tests_run++;
    if (init_cnt != 2 || next_cnt != 2) begin
      tests_failed++;
      $display("FAIL multi_pulses: init=%0d next=%0d expected init=2 next=2", init_cnt, next_cnt);
    end
  endtask

  task automatic test_timeout();
    int  cyc, rise_cyc, err_cyc, early_acc, acc_cyc;
    logic seen_low;
    do_reset();
    fixed_lat = 2;
    req_valid = 3'b011;
    req_first = 3'b011;
    req_last  = 3'b010;
    req_block = {512'h0, rand_blk(), rand_blk()};
    cyc = 0;
    while (req_accept === '0 && cyc < 20) begin @(negedge clk); cyc++; end
    tests_run++;
    if (req_accept !== 3'b001) begin tests_failed++; $display("FAIL timeout_first_accept: got %b expected 001", req_accept); end
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    req_first[0] = 1'b0;
    cyc = 0; rise_cyc = -1; err_cyc = -1; early_acc = 0; seen_low = 1'b0;
    while (err_cyc < 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (sha_ready === 1'b0) seen_low = 1'b1;
      if (seen_low && sha_ready === 1'b1 && rise_cyc < 0) rise_cyc = cyc;
      if (req_accept !== '0) early_acc++;
      if (arb_err !== '0) begin
        err_cyc = cyc;
        tests_run++;
        if (arb_err !== 3'b001) begin tests_failed++; $display("FAIL timeout_err_owner: got %b expected 001", arb_err); end
      end
    end
    tests_run++;
    if (rise_cyc < 0 || err_cyc - rise_cyc != 256) begin
      tests_failed++;
      $display("FAIL timeout_length: err at %0d, core ready at %0d, expected 256 apart", err_cyc, rise_cyc);
    end
    tests_run++;
    if (early_acc != 0) begin tests_failed++; $display("FAIL timeout_blocked: %0d accepts during hold, expected 0", early_acc); end
    acc_cyc = 0;
    while (req_accept === '0 && acc_cyc < 10) begin @(negedge clk); acc_cyc++; end
    tests_run++;
    if (req_accept !== 3'b010 || acc_cyc != 1) begin
      tests_failed++;
      $display("FAIL timeout_next_grant: got %b after %0d cycles, expected 010 after 1", req_accept, acc_cyc);
    end
    @(posedge clk);
    #1;
    req_valid = '0; req_first = '0; req_last = '0;
    cyc = 0;
    while (rsp_valid === '0 && cyc < 30) begin @(negedge clk); cyc++; end
    tests_run++;
    if (rsp_valid !== 3'b010) begin tests_failed++; $display("FAIL timeout_next_rsp: got %b expected 010", rsp_valid); end
    model_last = 1;
  endtask

  task automatic test_reset_mid();
    int   cyc;
    logic saw_dv;
    do_reset();
    fixed_lat = 6;
    req_valid = 3'b001; req_first = 3'b001; req_last = 3'b001;
    req_block = {512'h0, 512'h0, rand_blk()};
    cyc = 0;
    while (req_accept === '0 && cyc < 20) begin @(negedge clk); cyc++; end
    tests_run++;
    if (req_accept !== 3'b001) begin tests_failed++; $display("FAIL rstmid_accept: got %b expected 001", req_accept); end
    @(posedge clk); #1;
    req_valid = '0; req_first = '0; req_last = '0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({req_accept, rsp_valid, arb_err} !== '0 || rsp_digest !== '0 || sha_block !== '0 ||
        {sha_init, sha_next} !== 2'b00) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: accept=%b rsp=%b err=%b digest=%h expected all 0",
               req_accept, rsp_valid, arb_err, rsp_digest);
    end
    saw_dv = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (sha_digest_valid === 1'b1) saw_dv = 1'b1;
      tests_run++;
      if (rsp_valid !== '0 || arb_err !== '0 || req_accept !== '0) begin
        tests_failed++;
        $display("FAIL rstmid_stale: rsp=%b err=%b accept=%b expected 0", rsp_valid, arb_err, req_accept);
      end
    end
    tests_run++;
    if (saw_dv !== 1'b1) begin tests_failed++; $display("FAIL rstmid_core_done: digest_valid seen=%b expected 1", saw_dv); end
    model_last = N - 1;
  endtask

  task automatic test_nonfirst();
    int cyc;
    fixed_lat = 2;
    req_valid = 3'b100; req_first = 3'b000; req_last = 3'b100;
    req_block = {rand_blk(), 512'h0, 512'h0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      tests_run++;
      if (req_accept !== '0 || sha_init !== 1'b0 || sha_next !== 1'b0) begin
        tests_failed++;
        $display("FAIL nonfirst_ignored: accept=%b init=%b next=%b expected 0", req_accept, sha_init, sha_next);
      end
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_first[0] = 1'b1; req_last[0] = 1'b1;
    req_block[BW-1:0] = rand_blk();
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (req_accept !== 3'b001) begin tests_failed++; $display("FAIL nonfirst_still_idle: got %b expected 001", req_accept); end
    @(posedge clk); #1;
    req_valid[0] = 1'b0; req_first[0] = 1'b0; req_last[0] = 1'b0;
    cyc = 0;
    while (rsp_valid === '0 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (req_accept !== '0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL nonfirst_late_accept: got %b expected 0", req_accept);
      end
    end
    tests_run++;
    if (rsp_valid !== 3'b001) begin tests_failed++; $display("FAIL nonfirst_rsp: got %b expected 001", rsp_valid); end
    model_last = 0;
    clear_traffic();
    @(negedge clk);
  endtask

  task automatic test_random();
    fixed_lat = 0;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        nblk[i] = int'($urandom_range(3, 0));
        for (int b = 0; b < 4; b++) blks[i][b] = rand_blk();
      end
      if (nblk[0] + nblk[1] + nblk[2] == 0) nblk[r % N] = 1;
      run_traffic(600);
      repeat (int'($urandom_range(3, 0))) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_traffic();
    model_last = N - 1;
    test_reset();
    test_single();
    test_contention();
    test_multi_block();
    test_timeout();
    test_reset_mid();
    test_nonfirst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
